// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_reader
//  Purpose  : Reads a requested number of words from a show-ahead FIFO and
//             streams them out through a single valid/ready output register.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int WIDTH = 22,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready
);

    localparam logic [LEN_W-1:0] C_ZERO = '0;
    localparam logic [LEN_W-1:0] C_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic [WIDTH-1:0] r_data;

    logic             w_pop;
    logic             w_xfer;
    logic             w_kill;
    logic             w_zero_len;
    logic             w_finish;

    // A pop is allowed whenever the output register is empty or is being
    // drained in the same cycle, which gives back-to-back words.
    assign w_pop = !rst
                && (r_state == ST_RUN)
                && (r_remaining != C_ZERO)
                && !i_fifo_empty
                && !i_abort
                && (!r_valid || i_ready);

    assign w_xfer     = r_valid && i_ready;
    assign w_kill     = (r_state != ST_IDLE) && i_abort;
    assign w_zero_len = (r_state == ST_IDLE) && i_start && (i_len == C_ZERO);
    assign w_finish   = (r_state == ST_WAIT) && w_xfer && r_last && !i_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= C_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (i_start && (i_len != C_ZERO)) begin
                    w_state_nxt     = ST_RUN;
                    w_remaining_nxt = i_len;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = C_ZERO;
                end else if (w_pop) begin
                    w_remaining_nxt = r_remaining - C_ONE;
                    if (r_remaining == C_ONE) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = C_ZERO;
                end else if (w_xfer && r_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = C_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= w_zero_len || w_finish;
            if (w_kill) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_pop) begin
                r_data  <= i_fifo_data;
                r_valid <= 1'b1;
                r_last  <= (r_remaining == C_ONE);
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_fifo_rd_en = w_pop;
    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_last       = r_last;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_reader
//  Purpose  : Self-checking bench for fifo_reader against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

    localparam int WIDTH = 22;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             rd_en;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_len        (len),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd_en (rd_en),
        .o_valid      (valid),
        .o_data       (data),
        .o_last       (last),
        .i_ready      (ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // fq: words still inside the source FIFO; sref: words not yet delivered
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] sref[$];

    bit pend_pop  = 0;
    bit auto_push = 0;
    bit rnd_ready = 0;
    bit rnd_start = 0;
    bit full_rate = 0;

    bit m_active = 0;
    int m_len, m_xfer, m_pop, m_start_smp;
    int smp = 0;
    bit exp_done = 0, exp_busy = 0;
    bit p_kill = 1, p_rst = 1, p_pop = 0, p_pop_last = 0, p_hold = 0, p_xfer = 0, p_last = 0;
    logic [WIDTH-1:0] p_pop_word, p_data;

    always @(negedge clk) begin : mon
        bit was_active, kill, xfer, pop, nd_done;
        smp++;
        if (p_kill) begin
            check("kill_valid", valid, 0);
            check("kill_last", last, 0);
            check("kill_busy", busy, 0);
            check("kill_done", done, 0);
            if (p_rst) check("rst_data", data, 0);
        end else begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (p_pop) begin
                check("pop_valid", valid, 1);
                check("pop_data", data, p_pop_word);
                check("pop_last", last, p_pop_last);
            end else if (p_hold) begin
                check("hold_valid", valid, 1);
                check("hold_data", data, p_data);
                check("hold_last", last, p_last);
            end else if (p_xfer) begin
                check("drain_valid", valid, 0);
            end
        end

        was_active = m_active;
        kill       = rst || (abort && was_active);
        xfer       = valid && ready && !rst;
        pop        = rd_en && !fifo_empty;
        nd_done    = 0;

        if (fifo_empty) check("rd_en_empty", rd_en, 0);
        if (rst) check("rd_en_rst", rd_en, 0);
        if (valid && !ready) check("rd_en_stall", rd_en, 0);
        if (!was_active) begin
            check("rd_en_idle", rd_en, 0);
            if (!p_kill) check("valid_idle", valid, 0);
        end

        if (xfer && was_active) begin
            if (sref.size() == 0) check("xfer_extra", valid, 0);
            else check("xfer_data", data, sref.pop_front());
            m_xfer++;
            check("xfer_last", last, m_xfer == m_len);
            if (m_xfer == m_len && !kill) begin
                check("pop_count", m_pop, m_len);
                if (full_rate) check("burst_latency", smp - m_start_smp, m_len + 1);
                m_active = 0;
                nd_done  = 1;
            end
        end

        if (pop) begin
            m_pop++;
            p_pop_word = fifo_data;
            p_pop_last = (m_pop == m_len);
        end

        if (!was_active && start && !rst) begin
            if (len == '0) begin
                nd_done = 1;
            end else begin
                m_active    = 1;
                m_len       = int'(len);
                m_xfer      = 0;
                m_pop       = 0;
                m_start_smp = smp;
            end
        end
        if (kill) begin
            m_active = 0;
            nd_done  = 0;
        end

        exp_done = nd_done;
        exp_busy = m_active;
        p_kill   = kill;
        p_rst    = rst;
        p_pop    = pop && !kill;
        p_hold   = valid && !ready && !kill;
        p_xfer   = xfer && !kill;
        p_data   = data;
        p_last   = last;
        pend_pop = pop;
    end

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        sref.push_back(w);
        upd();
    endtask

    task automatic flush();
        fq.delete();
        sref.delete();
        upd();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_pop && fq.size() > 0) fq.delete(0);
        if (auto_push && fq.size() < 6 && $urandom_range(0, 99) < 50) push(WIDTH'($urandom));
        if (rnd_ready) ready = ($urandom_range(0, 99) < 70);
        if (rnd_start) begin
            // stray requests only well inside a burst, where they must be ignored
            if (m_active && (m_xfer + 1 < m_len)) begin
                start = ($urandom_range(0, 9) == 0);
                len   = LEN_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        upd();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while ((m_active || exp_done) && n < budget) begin
            step();
            n++;
        end
        check("burst_done_in_budget", m_active || exp_done, 0);
    endtask

    task automatic launch(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        step();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // full-rate burst of four
        for (int i = 0; i < 4; i++) push(WIDTH'($urandom));
        ready = 1'b1;
        full_rate = 1;
        launch(4);
        wait_idle(40);
        full_rate = 0;

        // backpressure
        for (int i = 0; i < 3; i++) push(WIDTH'($urandom));
        ready = 1'b0;
        launch(3);
        repeat (6) step();
        ready = 1'b1;
        wait_idle(40);

        // starved source
        launch(2);
        repeat (5) step();
        push(WIDTH'($urandom));
        push(WIDTH'($urandom));
        wait_idle(40);

        // zero length with a word waiting
        push(WIDTH'($urandom));
        launch(0);
        wait_idle(10);
        check("zero_len_fifo_left", fq.size(), 1);
        flush();

        // overlength source
        for (int i = 0; i < 6; i++) push(WIDTH'($urandom));
        launch(3);
        wait_idle(40);
        check("overlen_fifo_left", fq.size(), 3);
        flush();

        // abort after two words
        for (int i = 0; i < 5; i++) push(WIDTH'($urandom));
        launch(5);
        for (int n = 0; n < 30 && m_xfer < 2; n++) step();
        check("abort_reached_two", m_xfer >= 2, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        flush();
        repeat (3) step();

        // abort while idle is harmless
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // reset mid-burst, then a one-word burst
        for (int i = 0; i < 5; i++) push(WIDTH'($urandom));
        launch(5);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush();
        step();
        push(WIDTH'($urandom));
        launch(1);
        wait_idle(20);

        // maximum length with random flow control
        auto_push = 1;
        rnd_ready = 1;
        launch((1 << LEN_W) - 1);
        wait_idle(400);

        // random bursts, stray starts and occasional aborts
        rnd_start = 1;
        for (int b = 0; b < 30; b++) begin
            bit do_abort;
            do_abort = ($urandom_range(0, 5) == 0);
            launch($urandom_range(0, (1 << LEN_W) - 1));
            if (do_abort) begin
                repeat ($urandom_range(1, 8)) step();
                if (m_active) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    flush();
                end
            end
            wait_idle(500);
        end
        rnd_start = 0;
        auto_push = 0;
        rnd_ready = 0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
